// File: rtl/crc8_serial_if.sv
// Serial CRC bus: bit-strobe, clear and the registered CRC value.
// Latency: none, signal bundle only.
// Backpressure: none, the caller strobes enable once per bit.
interface crc8_serial_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             clear;
  logic             din;
  logic [WIDTH-1:0] crc_out;

  // Bit source (frame receiver) drives the strobes and reads the CRC.
  modport master (
    output enable,
    output clear,
    output din,
    input  crc_out
  );

  // CRC engine samples the strobes and presents the register.
  modport slave (
    input  enable,
    input  clear,
    input  din,
    output crc_out
  );
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial MSB-first CRC (non-reflected, no XOR-out), CRC-8/SMBUS by default.
// Latency: an accepted bit is visible on crc_out right after the edge that samples it.
// Backpressure: none; every cycle with enable high consumes din, clear overrides enable.
module crc8_serial #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h07,
  parameter logic [WIDTH-1:0] INIT  = 8'h00
) (
  input  logic         clk,
  input  logic         reset_n,
  crc8_serial_if.slave bus
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;
  logic             fb;

  // Feedback is the bit leaving the register combined with the incoming bit;
  // din only matters when enable is high, so an idle X on din cannot leak in.
  assign fb = crc_q[WIDTH-1] ^ bus.din;

  // Next-state: clear reloads INIT, enable shifts one bit, otherwise hold.
  always_comb begin
    crc_d = crc_q;
    if (bus.clear) begin
      crc_d = INIT;
    end else if (bus.enable) begin
      crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  // CRC register, forced to INIT immediately while reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign bus.crc_out = crc_q;

endmodule

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial: directed spec vectors plus random messages
// compared against a polynomial long-division model of CRC-8 (x^8+x^2+x+1).
module tb_crc8_serial;

  logic clk = 1'b0;
  logic reset_n;

  crc8_serial_if #(.WIDTH(8)) bus ();

  crc8_serial #(
    .WIDTH (8),
    .POLY  (8'h07),
    .INIT  (8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mq[$];   // every bit accepted since the last reset/clear

  // Remainder of (message * x^8) divided by x^8+x^2+x+1, computed by
  // schoolbook GF(2) long division over an explicit bit array.
  function automatic logic [7:0] model(input bit q[$]);
    bit         a[$];
    logic [8:0] gen;
    logic [7:0] r;
    gen = 9'h107;
    a = q;
    for (int j = 0; j < 8; j++) a.push_back(1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (a[i]) begin
        for (int j = 0; j < 9; j++) a[i+j] = a[i+j] ^ gen[8-j];
      end
    end
    for (int j = 0; j < 8; j++) r[7-j] = a[q.size()+j];
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one bit with enable high for one edge, then up to max_gap idle
  // cycles with din randomised; the register must hold through the idles.
  task automatic shift_bit(input bit b, input int max_gap, input string tag);
    int gap;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.clear  = 1'b0;
    bus.din    = b;
    @(posedge clk);
    #1;
    mq.push_back(b);
    check(tag, bus.crc_out, model(mq));
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.enable = 1'b0;
      bus.din    = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      check({tag, "_idle"}, bus.crc_out, model(mq));
    end
  endtask

  task automatic shift_msg(input logic [7:0] msg[$], input int max_gap, input string tag);
    logic [7:0] by;
    foreach (msg[k]) begin
      by = msg[k];
      for (int i = 7; i >= 0; i--) shift_bit(by[i], max_gap, tag);
    end
    @(negedge clk);
    bus.enable = 1'b0;
    bus.din    = 1'($urandom_range(1, 0));
  endtask

  // Clear pulse with random enable/din alongside; clear must win.
  task automatic do_clear(input bit en);
    @(negedge clk);
    bus.clear  = 1'b1;
    bus.enable = en;
    bus.din    = 1'($urandom_range(1, 0));
    @(posedge clk);
    #1;
    mq.delete();
    check("clear", bus.crc_out, 8'h00);
    @(negedge clk);
    bus.clear  = 1'b0;
    bus.enable = 1'b0;
  endtask

  initial begin
    logic [7:0] m[$];
    logic [7:0] c;
    int         len;

    reset_n    = 1'b1;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.din    = 1'b0;

    // Scramble the register a little before the first reset.
    @(negedge clk);
    bus.enable = 1'b1;
    bus.din    = 1'b1;
    repeat (2) @(negedge clk);

    // 1: async reset mid-cycle while enable is high and din toggles.
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async", bus.crc_out, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.din = ~bus.din;
      @(posedge clk);
      #1;
      check("reset_held", bus.crc_out, 8'h00);
    end
    @(negedge clk);
    bus.enable = 1'b0;
    reset_n    = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", bus.crc_out, 8'h00);
    mq.delete();

    // 2: single bytes from INIT.
    m = '{8'h01};
    shift_msg(m, 0, "b01");
    check("b01_final", bus.crc_out, 8'h07);
    do_clear(1'b0);
    m = '{8'h80};
    shift_msg(m, 0, "b80");
    check("b80_final", bus.crc_out, 8'h89);
    do_clear(1'b1);

    // 3: standard check string, enable held high across all 72 bits.
    m = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    shift_msg(m, 0, "check");
    check("check_final", bus.crc_out, 8'hF4);
    do_clear(1'b0);

    // 4: residue.
    m = '{8'h80, 8'h89};
    shift_msg(m, 0, "resid");
    check("resid_final", bus.crc_out, 8'h00);
    do_clear(1'b1);

    // 5: the same vectors with random idle gaps and random idle din.
    m = '{8'h01};
    shift_msg(m, 3, "g01");
    check("g01_final", bus.crc_out, 8'h07);
    do_clear(1'b0);
    m = '{8'h80};
    shift_msg(m, 3, "g80");
    check("g80_final", bus.crc_out, 8'h89);
    do_clear(1'b0);
    m = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    shift_msg(m, 2, "gcheck");
    check("gcheck_final", bus.crc_out, 8'hF4);
    do_clear(1'b0);
    m = '{8'h80, 8'h89};
    shift_msg(m, 3, "gresid");
    check("gresid_final", bus.crc_out, 8'h00);
    do_clear(1'b0);

    // 6: clear together with enable after 4 bits discards that bit.
    for (int i = 0; i < 4; i++) shift_bit(1'($urandom_range(1, 0)), 0, "pre_clr");
    do_clear(1'b1);
    m = '{8'h01};
    shift_msg(m, 0, "post_clr");
    check("post_clr_final", bus.crc_out, 8'h07);

    // Reset mid-stream aborts; computation restarts from INIT.
    do_clear(1'b0);
    for (int i = 0; i < 3; i++) shift_bit(1'($urandom_range(1, 0)), 1, "pre_rst");
    @(negedge clk);
    bus.enable = 1'b1;
    bus.din    = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_async", bus.crc_out, 8'h00);
    @(negedge clk);
    bus.enable = 1'b0;
    reset_n    = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    check("midrst_release", bus.crc_out, 8'h00);
    m = '{8'h01};
    shift_msg(m, 1, "post_rst");
    check("post_rst_final", bus.crc_out, 8'h07);
    do_clear(1'b0);

    // Random messages with their own CRC appended must leave a zero residue.
    for (int t = 0; t < 6; t++) begin
      len = int'($urandom_range(4, 1));
      m.delete();
      mq.delete();
      for (int k = 0; k < len; k++) begin
        m.push_back(8'($urandom));
        for (int i = 7; i >= 0; i--) mq.push_back(m[k][i]);
      end
      c = model(mq);
      mq.delete();
      m.push_back(c);
      shift_msg(m, 2, "rand");
      check("rand_residue", bus.crc_out, 8'h00);
      do_clear(1'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
